// File: rtl/dbg_req_pkg.sv
// Shared types and constants for the debug-request arbiter.
package dbg_req_pkg;

    localparam int DEFAULT_NUM_REQ    = 2;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Payload carried for every accepted debug request.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } dbg_req_t;

    // IDLE arbitrates round-robin; LOCKED pins the grant to one source.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Round-robin successor of idx among n sources.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dbg_req_fifo.sv
// Output queue of the arbiter: FIFO of {payload, src} with valid/ready on both sides.
module dbg_req_fifo
    import dbg_req_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int SRC_W = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  dbg_req_t         in_req,
    input  logic [SRC_W-1:0] in_src,
    output logic             out_valid,
    input  logic             out_ready,
    output dbg_req_t         out_req,
    output logic [SRC_W-1:0] out_src
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    dbg_req_t         mem_req [DEPTH];
    logic [SRC_W-1:0] mem_src [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Handshakes are forced low during reset so nothing moves while state is being cleared.
    assign in_ready  = !reset && (count != FULL_CNT);
    assign out_valid = !reset && (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head entry is read straight from storage; it cannot change until popped.
    assign out_req = mem_req[rd_ptr];
    assign out_src = mem_src[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage write port.
    always_ff @(posedge clock) begin
        // NOTE: storage is deliberately not reset; emptiness is tracked by count, so stale words are never visible.
        if (push) begin
            mem_req[wr_ptr] <= in_req;
            mem_src[wr_ptr] <= in_src;
        end
    end

endmodule

// File: rtl/dbg_req_arb.sv
// Round-robin debug-request arbiter with lock support, feeding an output FIFO.
module dbg_req_arb
    import dbg_req_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                in_valid,
    output logic [NUM_REQ-1:0]                in_ready,
    input  logic [NUM_REQ-1:0][31:0]          in_addr,
    input  logic [NUM_REQ-1:0][31:0]          in_data,
    input  logic [NUM_REQ-1:0]                in_lock,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [31:0]                       out_addr,
    output logic [31:0]                       out_data,
    output logic [$clog2(NUM_REQ)-1:0]        out_src,
    output logic                              busy
);

    localparam int SRC_W = $clog2(NUM_REQ);

    arb_state_e       state;
    arb_state_e       state_next;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] lock_owner;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_valid;
    logic             fifo_in_ready;
    logic             xfer;
    dbg_req_t         fifo_in_req;
    dbg_req_t         fifo_out_req;

    // A source beat moves whenever the granted source is valid and the queue has room.
    assign xfer        = grant_valid && fifo_in_ready;
    assign fifo_in_req = '{addr: in_addr[grant_idx], data: in_data[grant_idx]};

    // Arbitration state register.
    always_ff @(posedge clock) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_next;
    end

    // Next-state: enter LOCKED on a locked beat, leave on the owner's unlocked beat.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:   if (xfer && in_lock[grant_idx])   state_next = ARB_LOCKED;
            ARB_LOCKED: if (xfer && !in_lock[lock_owner]) state_next = ARB_IDLE;
            default:    state_next = ARB_IDLE;
        endcase
    end

    // Grant and per-source ready, derived only from registered state and in_valid.
    always_comb begin
        int cand;
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        in_ready    = '0;
        cand        = 0;
        if (state == ARB_LOCKED) begin
            grant_valid = in_valid[lock_owner];
            grant_idx   = lock_owner;
        end else begin
            // Walk candidates from farthest to nearest so the first valid one after rr_ptr wins last.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = int'(rr_ptr) + k;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                if (in_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SRC_W'(cand);
                end
            end
        end
        if (grant_valid && fifo_in_ready) in_ready[grant_idx] = 1'b1;
    end

    // Round-robin pointer and lock owner; both move only on a source transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr     <= '0;
            lock_owner <= '0;
        end else if (xfer) begin
            if (state == ARB_IDLE && in_lock[grant_idx]) begin
                lock_owner <= grant_idx;
            end else if (!in_lock[grant_idx]) begin
                rr_ptr <= SRC_W'(rr_next(int'(grant_idx), NUM_REQ));
            end
        end
    end

    dbg_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .SRC_W (SRC_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (grant_valid),
        .in_ready  (fifo_in_ready),
        .in_req    (fifo_in_req),
        .in_src    (grant_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_req   (fifo_out_req),
        .out_src   (out_src)
    );

    assign out_addr = fifo_out_req.addr;
    assign out_data = fifo_out_req.data;
    assign busy     = out_valid || (!reset && state == ARB_LOCKED);

endmodule

// File: doc/dbg_req_arb.md
DBG_REQ_ARB -- requirements
Module: dbg_req_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of debug-request sources; legal range 2..4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output queue entries; power of two, minimum 2.
REQ-003 SHALL have port clock, input, 1 bit: clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, [NUM_REQ]: per-source request valid.
REQ-006 SHALL have port in_ready, output, [NUM_REQ]: per-source accept.
REQ-007 SHALL have port in_addr, input, [NUM_REQ][32]: per-source request address.
REQ-008 SHALL have port in_data, input, [NUM_REQ][32]: per-source request data.
REQ-009 SHALL have port in_lock, input, [NUM_REQ]: hold grant after this beat.
REQ-010 SHALL have port out_valid, output, 1 bit: queue head valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-012 SHALL have ports out_addr and out_data, output, 32 bits each: queue head payload.
REQ-013 SHALL have port out_src, output, $clog2(NUM_REQ) bits: source index of the head entry.
REQ-014 SHALL have port busy, output, 1 bit: queue non-empty or lock held.

Function
REQ-015 SHALL transfer a source beat when in_valid[i] && in_ready[i], and a downstream beat when out_valid && out_ready.
REQ-016 SHALL assert in_ready for at most one source per cycle: the granted source, and only when the queue is not full.
REQ-017 SHALL compute in_ready and the grant combinationally from registered state and in_valid only; SHALL NOT depend on out_ready (no full-queue bypass).
REQ-018 SHALL grant round-robin: search starts at rr_ptr, ascending with wrap, first source with in_valid set wins.
REQ-019 SHALL set rr_ptr to (granted index + 1) mod NUM_REQ after each unlocked transfer; rr_ptr SHALL NOT change in cycles without a transfer.
REQ-020 SHALL use two arbitration states. IDLE: round-robin grant. LOCKED: grant fixed to lock_owner.
REQ-021 SHALL move IDLE->LOCKED on a transfer with in_lock=1, storing lock_owner. LOCKED->IDLE on an owner transfer with in_lock=0, advancing rr_ptr past the owner.
REQ-022 SHALL, in LOCKED state, give no in_ready to any other source, even when the owner's in_valid is low.
REQ-023 SHALL enqueue {addr, data, src} on a source transfer; the entry becomes visible on out_* the next cycle (latency 1).
REQ-024 SHALL dequeue on a downstream transfer; enqueue and dequeue in the same cycle leave the count unchanged.
REQ-025 SHALL wrap read and write pointers modulo FIFO_DEPTH; the count register spans 0..FIFO_DEPTH; full = (count==FIFO_DEPTH), empty = (count==0).
REQ-026 SHALL hold out_addr, out_data and out_src stable while out_valid=1 and out_ready=0.
REQ-027 SHALL preserve FIFO order: the output order equals the order of acceptance.

Reset
REQ-028 SHALL, while reset=1, drive out_valid=0, in_ready all 0 and busy=0, and set rr_ptr=0, state=IDLE, count=0, pointers=0.
REQ-029 SHALL, on reset mid-operation, discard queued entries and any held lock; out_addr, out_data and out_src SHALL NOT require reset.

Structure
REQ-030 SHALL place the dbg_req_t struct {addr[31:0], data[31:0]}, the arbitration-state enum and the default parameter constants in the package dbg_req_pkg.
REQ-031 SHALL implement the queue as the sub-module dbg_req_fifo (parameter DEPTH, payload dbg_req_t plus src, valid/ready on both sides).

Verification
REQ-032 SHALL cover: src0 and src1 valid continuously, out_ready=1 -> grants alternate 0,1,0,1; out_src follows each accepted beat by 1 cycle.
REQ-033 SHALL cover: src0 sends 3 beats with in_lock=1,1,0 while src1 stays valid -> src0 beats 0x100/0x104/0x108 are queued back-to-back, then src1 is granted.
REQ-034 SHALL cover: out_ready=0 and 5 requests offered -> exactly 4 are accepted, in_ready=0 while full, out_* stable; one out_ready pulse dequeues 1 and accepts 1.
REQ-035 SHALL cover: FIFO_DEPTH=4 with 10 beats streamed, enqueue and dequeue every cycle -> count stays 1, pointers wrap, data order is intact.
REQ-036 SHALL cover: reset asserted for 1 cycle while LOCKED with 3 entries queued -> next cycle out_valid=0, busy=0, rr_ptr=0, and src1 is granted immediately.
